// File: rtl/pe_column_ctrl_if.sv
// Buffer read bus and result handshake between pe_column_ctrl and its neighbours.
// The master modport is the controller side.
interface pe_column_ctrl_if #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_W    = 10
);
  logic                 buf_rd;
  logic [ADDR_W-1:0]    buf_addr;
  logic [DATA_SIZE-1:0] w_data;
  logic [DATA_SIZE-1:0] map_data_0, map_data_1, map_data_2, map_data_3;
  logic [DATA_SIZE-1:0] res_0, res_1, res_2, res_3;
  logic                 res_vld;
  logic                 res_rdy;

  modport master (
    output buf_rd, buf_addr, res_0, res_1, res_2, res_3, res_vld,
    input  w_data, map_data_0, map_data_1, map_data_2, map_data_3, res_rdy
  );

  modport slave (
    input  buf_rd, buf_addr, res_0, res_1, res_2, res_3, res_vld,
    output w_data, map_data_0, map_data_1, map_data_2, map_data_3, res_rdy
  );
endinterface

// File: rtl/pe_column_ctrl.sv
// Tap sequencer, drain timer and result handshake for one 4-row PE column.
// Optional feature macro PSUM_ACC_EN: load psum_in_0..3 into din_0..3 on the first tap.
module pe_column_ctrl #(
  parameter int DATA_SIZE = 8,
  parameter int KSIZE     = 5,
  parameter int CH_W      = 4,
  parameter int PE_LAT    = 2,
  parameter int ADDR_W    = 10
) (
  input  logic                 clk_cal,
  input  logic                 rst_cal,
  input  logic                 start,
  input  logic [CH_W-1:0]      cfg_nchan,
  input  logic [DATA_SIZE-1:0] cfg_bias,
  output logic                 busy,
  output logic                 done,
  pe_column_ctrl_if.master     bus,
  input  logic [DATA_SIZE-1:0] psum_in_0, psum_in_1, psum_in_2, psum_in_3,
  output logic [DATA_SIZE-1:0] IWeight,
  output logic [DATA_SIZE-1:0] IMap_0, IMap_1, IMap_2, IMap_3,
  output logic                 IweightVld,
  output logic                 ImapVld_0, ImapVld_1, ImapVld_2, ImapVld_3,
  output logic [DATA_SIZE-1:0] din_0, din_1, din_2, din_3,
  output logic                 dinVld,
  output logic [DATA_SIZE-1:0] bias,
  input  logic [DATA_SIZE-1:0] dout_0, dout_1, dout_2, dout_3
);
  localparam int NTAP  = KSIZE * KSIZE;
  localparam int TAP_W = $clog2(NTAP + 1);
  localparam int DRN_W = $clog2(PE_LAT + 1) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  if (NTAP * ((1 << CH_W) - 1) > (1 << ADDR_W)) begin : g_addr_overflow
    $error("pe_column_ctrl: KSIZE*KSIZE*(2^CH_W-1) taps do not fit in ADDR_W");
  end

  logic [2:0]                 state_q, state_d;
  logic [CH_W-1:0]            nchan_q, nchan_d, chan_q, chan_d;
  logic [TAP_W-1:0]           tap_q, tap_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [DRN_W-1:0]           drn_q, drn_d;
  logic [DATA_SIZE-1:0]       bias_q, bias_d;
  logic [3:0][DATA_SIZE-1:0]  res_q, res_d;
  logic                       vld_q, vld_d, din_vld_q, din_vld_d;
  logic                       rd, last_tap;

  // A zero-channel pass spends one RUN cycle with no reads before DONE.
  assign rd       = (state_q == S_RUN) && (nchan_q != '0);
  assign last_tap = (tap_q == TAP_W'(NTAP - 1)) && (chan_q == nchan_q - CH_W'(1));

  always_comb begin
    // NOTE: every _d defaults to its _q so no path through the case infers a latch.
    state_d   = state_q;
    nchan_d   = nchan_q;
    chan_d    = chan_q;
    tap_d     = tap_q;
    addr_d    = addr_q;
    drn_d     = drn_q;
    bias_d    = bias_q;
    res_d     = res_q;
    vld_d     = rd;
    din_vld_d = rd && (addr_q == '0);
    case (state_q)
      S_IDLE: if (start) begin
        nchan_d = cfg_nchan;
        bias_d  = cfg_bias;
        chan_d  = '0;
        tap_d   = '0;
        addr_d  = '0;
        drn_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (nchan_q == '0) begin
          state_d = S_DONE;
        end else if (last_tap) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (tap_q == TAP_W'(NTAP - 1)) begin
            tap_d  = '0;
            chan_d = chan_q + CH_W'(1);
          end else begin
            tap_d = tap_q + TAP_W'(1);
          end
        end
      end
      // drn_q==0 is the cycle of the last valid tap; dout settles PE_LAT cycles later.
      S_DRAIN: begin
        if (drn_q == DRN_W'(PE_LAT)) begin
          res_d   = {dout_3, dout_2, dout_1, dout_0};
          state_d = S_OUT;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      S_OUT:   if (bus.res_rdy) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_cal or negedge rst_cal) begin
    if (!rst_cal) begin
      state_q   <= S_IDLE;
      nchan_q   <= '0;
      chan_q    <= '0;
      tap_q     <= '0;
      addr_q    <= '0;
      drn_q     <= '0;
      bias_q    <= '0;
      // NOTE: the result registers are reset too, since res_0..3 must read 0 out of reset.
      res_q     <= '0;
      vld_q     <= 1'b0;
      din_vld_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge _d values.
      state_q   <= state_d;
      nchan_q   <= nchan_d;
      chan_q    <= chan_d;
      tap_q     <= tap_d;
      addr_q    <= addr_d;
      drn_q     <= drn_d;
      bias_q    <= bias_d;
      res_q     <= res_d;
      vld_q     <= vld_d;
      din_vld_q <= din_vld_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign bus.buf_rd   = rd;
  assign bus.buf_addr = addr_q;
  assign bus.res_vld  = (state_q == S_OUT);
  assign bus.res_0    = res_q[0];
  assign bus.res_1    = res_q[1];
  assign bus.res_2    = res_q[2];
  assign bus.res_3    = res_q[3];

  assign IWeight    = bus.w_data;
  assign IMap_0     = bus.map_data_0;
  assign IMap_1     = bus.map_data_1;
  assign IMap_2     = bus.map_data_2;
  assign IMap_3     = bus.map_data_3;
  assign IweightVld = vld_q;
  assign ImapVld_0  = vld_q;
  assign ImapVld_1  = vld_q;
  assign ImapVld_2  = vld_q;
  assign ImapVld_3  = vld_q;
  assign dinVld     = din_vld_q;
  assign bias       = bias_q;

`ifdef PSUM_ACC_EN
  assign din_0 = din_vld_q ? psum_in_0 : '0;
  assign din_1 = din_vld_q ? psum_in_1 : '0;
  assign din_2 = din_vld_q ? psum_in_2 : '0;
  assign din_3 = din_vld_q ? psum_in_3 : '0;
`else
  logic unused_psum;
  assign unused_psum = ^{psum_in_0, psum_in_1, psum_in_2, psum_in_3};
  assign din_0 = '0;
  assign din_1 = '0;
  assign din_2 = '0;
  assign din_3 = '0;
`endif
endmodule

// File: tb/tb_pe_column_ctrl.sv
// Directed bench for pe_column_ctrl: a table of pass configurations with
// hand-computed timing/results, plus reset-state and mid-pass-reset sequences.
module tb_pe_column_ctrl;
  localparam int DS = 8;
  localparam int AW = 10;
  localparam int CW = 4;

`ifdef PSUM_ACC_EN
  localparam int DIN_BASE = 1;
`else
  localparam int DIN_BASE = 0;
`endif

  logic          clk_cal = 1'b0;
  logic          rst_cal = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] cfg_nchan = '0;
  logic [DS-1:0] cfg_bias = '0;
  logic          busy, done;
  logic [DS-1:0] psum_in_0, psum_in_1, psum_in_2, psum_in_3;
  logic [DS-1:0] IWeight, IMap_0, IMap_1, IMap_2, IMap_3;
  logic          IweightVld, ImapVld_0, ImapVld_1, ImapVld_2, ImapVld_3;
  logic [DS-1:0] din_0, din_1, din_2, din_3;
  logic          dinVld;
  logic [DS-1:0] bias;
  logic [DS-1:0] dout_0, dout_1, dout_2, dout_3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_cal = ~clk_cal;

  pe_column_ctrl_if #(.DATA_SIZE(DS), .ADDR_W(AW)) bus ();

  pe_column_ctrl #(.DATA_SIZE(DS), .KSIZE(5), .CH_W(CW), .PE_LAT(2), .ADDR_W(AW)) dut (
    .clk_cal(clk_cal), .rst_cal(rst_cal), .start(start),
    .cfg_nchan(cfg_nchan), .cfg_bias(cfg_bias), .busy(busy), .done(done),
    .bus(bus),
    .psum_in_0(psum_in_0), .psum_in_1(psum_in_1), .psum_in_2(psum_in_2), .psum_in_3(psum_in_3),
    .IWeight(IWeight), .IMap_0(IMap_0), .IMap_1(IMap_1), .IMap_2(IMap_2), .IMap_3(IMap_3),
    .IweightVld(IweightVld), .ImapVld_0(ImapVld_0), .ImapVld_1(ImapVld_1),
    .ImapVld_2(ImapVld_2), .ImapVld_3(ImapVld_3),
    .din_0(din_0), .din_1(din_1), .din_2(din_2), .din_3(din_3), .dinVld(dinVld),
    .bias(bias), .dout_0(dout_0), .dout_1(dout_1), .dout_2(dout_2), .dout_3(dout_3)
  );

  typedef struct {
    logic [CW-1:0] nchan;
    logic [DS-1:0] bias;
    int            rdy_delay;
    bit            glitch;
    int            exp_reads;
    int            exp_last_addr;
    int            exp_vld_first;
    int            exp_vld_last;
    int            exp_vld_cnt;
    int            exp_din_k;
    int            exp_rv_first;
    int            exp_rv_cnt;
    int            exp_done_k;
    int            exp_res0;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_data(input int k);
    dout_0 = DS'(k * 4 + 0);
    dout_1 = DS'(k * 4 + 1);
    dout_2 = DS'(k * 4 + 2);
    dout_3 = DS'(k * 4 + 3);
    bus.w_data     = DS'(k + 7);
    bus.map_data_0 = DS'(k);
    bus.map_data_1 = DS'(k + 16);
    bus.map_data_2 = DS'(k + 32);
    bus.map_data_3 = DS'(k + 48);
  endtask

  // k counts edges after the start-sampling edge T; values observed at the
  // negedge before edge T+k are the values "at T+k".
  task automatic run_pass(input vec_t v, input int idx);
    int reads = 0, last_addr = -1, addr_err = 0;
    int vld_first = -1, vld_last = -1, vld_cnt = 0, vld_err = 0, prev_rd = 0;
    int din_cnt = 0, din_k = -1, din_err = 0;
    int d0 = 0, d1 = 0, d2 = 0, d3 = 0;
    int rv_first = -1, rv_cnt = 0, stable_err = 0;
    int r0 = 0, r1 = 0, r2 = 0, r3 = 0;
    int done_k = -1, done_cnt = 0, busy_err = 0, pass_err = 0;
    string p;
    p = $sformatf("v%0d", idx);

    @(negedge clk_cal);
    start = 1'b1; cfg_nchan = v.nchan; cfg_bias = v.bias; bus.res_rdy = 1'b0;
    drive_data(0);
    @(posedge clk_cal);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk_cal);
      start = 1'b0; cfg_nchan = 4'hF; cfg_bias = 8'hEE;
      if (v.glitch && (k == 5 || k == 12)) begin
        start = 1'b1; cfg_nchan = 4'd3; cfg_bias = 8'hFF;
      end
      if (bus.buf_rd) begin
        if (int'(bus.buf_addr) != reads) addr_err++;
        reads++;
        last_addr = int'(bus.buf_addr);
      end
      if ({ImapVld_0, ImapVld_1, ImapVld_2, ImapVld_3} != {4{IweightVld}}) vld_err++;
      if (int'(IweightVld) != prev_rd) vld_err++;
      prev_rd = int'(bus.buf_rd);
      if (IweightVld) begin
        if (vld_first < 0) vld_first = k;
        vld_last = k;
        vld_cnt++;
      end
      if (IWeight != bus.w_data || IMap_0 != bus.map_data_0 || IMap_1 != bus.map_data_1 ||
          IMap_2 != bus.map_data_2 || IMap_3 != bus.map_data_3) pass_err++;
      if (dinVld) begin
        din_cnt++; din_k = k;
        d0 = int'(din_0); d1 = int'(din_1); d2 = int'(din_2); d3 = int'(din_3);
      end else if ({din_0, din_1, din_2, din_3} != '0) begin
        din_err++;
      end
      if (bus.res_vld) begin
        if (rv_cnt == 0) begin
          rv_first = k;
          r0 = int'(bus.res_0); r1 = int'(bus.res_1); r2 = int'(bus.res_2); r3 = int'(bus.res_3);
        end else if (r0 != int'(bus.res_0) || r1 != int'(bus.res_1) ||
                     r2 != int'(bus.res_2) || r3 != int'(bus.res_3)) begin
          stable_err++;
        end
        rv_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (!busy && done_k < 0) busy_err++;
      if (done_k >= 0 && k >= done_k + 2) break;
      bus.res_rdy = bus.res_vld && (rv_cnt > v.rdy_delay);
      drive_data(k);
      @(posedge clk_cal);
    end
    bus.res_rdy = 1'b0;

    check({p, " reads"},       reads,     v.exp_reads);
    check({p, " last_addr"},   last_addr, v.exp_last_addr);
    check({p, " addr_seq"},    addr_err,  0);
    check({p, " vld_first"},   vld_first, v.exp_vld_first);
    check({p, " vld_last"},    vld_last,  v.exp_vld_last);
    check({p, " vld_cnt"},     vld_cnt,   v.exp_vld_cnt);
    check({p, " vld_align"},   vld_err,   0);
    check({p, " passthru"},    pass_err,  0);
    check({p, " din_pulses"},  din_cnt,   (v.exp_din_k < 0) ? 0 : 1);
    check({p, " din_k"},       din_k,     v.exp_din_k);
    check({p, " din_idle"},    din_err,   0);
    if (din_cnt == 1) begin
      check({p, " din_0"}, d0, DIN_BASE * 1);
      check({p, " din_1"}, d1, DIN_BASE * 2);
      check({p, " din_2"}, d2, DIN_BASE * 3);
      check({p, " din_3"}, d3, DIN_BASE * 4);
    end
    check({p, " res_vld_first"}, rv_first, v.exp_rv_first);
    check({p, " res_vld_cnt"},   rv_cnt,   v.exp_rv_cnt);
    check({p, " res_stable"},    stable_err, 0);
    if (rv_cnt > 0) begin
      check({p, " res_0"}, r0, v.exp_res0);
      check({p, " res_1"}, r1, v.exp_res0 + 1);
      check({p, " res_2"}, r2, v.exp_res0 + 2);
      check({p, " res_3"}, r3, v.exp_res0 + 3);
    end
    check({p, " done_k"},   done_k,     v.exp_done_k);
    check({p, " done_cnt"}, done_cnt,   1);
    check({p, " busy"},     busy_err,   0);
    check({p, " bias"},     int'(bias), int'(v.bias));
    check({p, " idle"},     int'(busy), 0);
  endtask

  task automatic check_all_zero(input string p);
    check({p, " busy"},     int'(busy),           0);
    check({p, " done"},     int'(done),           0);
    check({p, " buf_rd"},   int'(bus.buf_rd),     0);
    check({p, " buf_addr"}, int'(bus.buf_addr),   0);
    check({p, " vld"},      int'({IweightVld, ImapVld_0, ImapVld_1, ImapVld_2, ImapVld_3}), 0);
    check({p, " dinVld"},   int'(dinVld),         0);
    check({p, " din"},      int'({din_0, din_1, din_2, din_3}), 0);
    check({p, " bias"},     int'(bias),           0);
    check({p, " res"},      int'({bus.res_0, bus.res_1, bus.res_2, bus.res_3}), 0);
    check({p, " res_vld"},  int'(bus.res_vld),    0);
  endtask

  initial begin
    //            nchan  bias   dly gl reads last vf  vl  vc  dk  rvf rvc dn  res0
    vecs[0] = '{4'd1, 8'h03,  0, 0,  25,  24, 2,  26, 25, 2,  29, 1,  30, 112};
    vecs[1] = '{4'd3, 8'hA5,  0, 0,  75,  74, 2,  76, 75, 2,  79, 1,  80, 56};
    vecs[2] = '{4'd1, 8'h7E, 10, 0,  25,  24, 2,  26, 25, 2,  29, 11, 40, 112};
    vecs[3] = '{4'd0, 8'h11,  0, 0,   0,  -1, -1, -1, 0,  -1, -1, 0,  2,  0};
    vecs[4] = '{4'd1, 8'h42,  0, 1,  25,  24, 2,  26, 25, 2,  29, 1,  30, 112};
    vecs[5] = '{4'd2, 8'h01,  3, 0,  50,  49, 2,  51, 50, 2,  54, 4,  58, 212};

    psum_in_0 = 8'd1; psum_in_1 = 8'd2; psum_in_2 = 8'd3; psum_in_3 = 8'd4;
    bus.res_rdy = 1'b0;
    drive_data(0);

    #12;
    check_all_zero("reset");
    @(negedge clk_cal);
    rst_cal = 1'b1;
    repeat (2) @(negedge clk_cal);
    check_all_zero("post_reset");

    for (int i = 0; i < 6; i++) run_pass(vecs[i], i);

    // Mid-pass reset at tap 12, then a clean pass afterwards.
    begin
      int hit = 0, rv_seen = 0, done_seen = 0;
      @(negedge clk_cal);
      start = 1'b1; cfg_nchan = 4'd1; cfg_bias = 8'h5A;
      @(negedge clk_cal);
      start = 1'b0;
      for (int i = 0; i < 60; i++) begin
        if (bus.buf_rd && bus.buf_addr == 10'd12) begin
          hit = 1;
          break;
        end
        @(negedge clk_cal);
      end
      check("midrst reached_tap12", hit, 1);
      rst_cal = 1'b0;
      #1;
      check_all_zero("midrst");
      @(negedge clk_cal);
      rst_cal = 1'b1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk_cal);
        if (bus.res_vld) rv_seen++;
        if (done) done_seen++;
      end
      check("midrst no_res_vld", rv_seen, 0);
      check("midrst no_done",    done_seen, 0);
      run_pass(vecs[0], 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
